// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Coin codes double as the HopperCoin output encoding.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_VEND     = 3'd2,
        ST_CHG_SEL  = 3'd3,
        ST_CHG_WAIT = 3'd4,
        ST_CHG_GAP  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_Q    = 2'b01,
        COIN_D    = 2'b10,
        COIN_N    = 2'b11
    } coin_t;

    localparam logic [6:0] VAL_Q = 7'd25;
    localparam logic [6:0] VAL_D = 7'd10;
    localparam logic [6:0] VAL_N = 7'd5;

    localparam int MAX_CREDIT_DEF = 95;

    // Timeout-mask bit owned by each coin type: bit0 quarter, bit1 dime, bit2 nickel.
    function automatic logic [2:0] coin_mask_bit(input coin_t c);
        case (c)
            COIN_Q:  return 3'b001;
            COIN_D:  return 3'b010;
            COIN_N:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/change_select.sv
// Greedy change-coin picker: largest coin not exceeding the credit whose tube
// is stocked and which has not timed out during the current transaction.
module change_select
    import vend_pkg::*;
(
    input  logic [6:0] credit,
    input  logic       qempty,
    input  logic       dempty,
    input  logic       nempty,
    input  logic [2:0] tmo_mask,
    output coin_t      coin,
    output logic [6:0] value
);

    always_comb begin
        coin  = COIN_NONE;
        value = '0;
        if (credit >= VAL_Q && !qempty && !tmo_mask[0]) begin
            coin  = COIN_Q;
            value = VAL_Q;
        end else if (credit >= VAL_D && !dempty && !tmo_mask[1]) begin
            coin  = COIN_D;
            value = VAL_D;
        end else if (credit >= VAL_N && !nempty && !tmo_mask[2]) begin
            coin  = COIN_N;
            value = VAL_N;
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Single owner of vending credit: accepts coins, arbitrates Buy/Refund,
// strobes the dispenser and pays change one coin at a time via the hopper.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
    parameter int PRICE0      = 25,
    parameter int PRICE1      = 50,
    parameter int PRICE2      = 65,
    parameter int PRICE3      = 85,
    parameter int VEND_CYCLES = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Quarters,
    input  logic       Dimes,
    input  logic       Nickles,
    input  logic [3:0] Buy,
    input  logic       Refund,
    input  logic       HopperAck,
    input  logic       QEmpty,
    input  logic       DEmpty,
    input  logic       NEmpty,
    output logic [6:0] Credit,
    output logic [3:0] Vending,
    output logic       HopperReq,
    output logic [1:0] HopperCoin,
    output logic       Reject,
    output logic       Busy,
    output logic       Error
);

    localparam int VW = $clog2(VEND_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t        state, state_n;
    logic [6:0]    credit, credit_n;
    logic [6:0]    hval, hval_n;
    logic [3:0]    item, item_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [2:0]    mask, mask_n;
    logic          req, req_n;
    coin_t         hcoin, hcoin_n;
    logic          reject, reject_n;
    logic          error, error_n;

    coin_t         sel_coin;
    logic [6:0]    sel_value;
    logic          coin_any;
    logic [6:0]    coin_sum;
    logic [7:0]    credit_plus;
    logic [3:0]    buy_oh;
    logic [6:0]    buy_price;
    logic          buy_hit;

    function automatic logic [6:0] price_of(input int idx);
        case (idx)
            0:       return 7'(PRICE0);
            1:       return 7'(PRICE1);
            2:       return 7'(PRICE2);
            default: return 7'(PRICE3);
        endcase
    endfunction

    assign coin_any    = Quarters | Dimes | Nickles;
    assign coin_sum    = (Quarters ? VAL_Q : 7'd0) + (Dimes ? VAL_D : 7'd0) + (Nickles ? VAL_N : 7'd0);
    assign credit_plus = {1'b0, credit} + {1'b0, coin_sum};

    // Descending scan so the lowest set Buy bit is the one that sticks.
    always_comb begin
        buy_oh    = '0;
        buy_price = '0;
        for (int i = 3; i >= 0; i--) begin
            if (Buy[i]) begin
                buy_oh    = '0;
                buy_oh[i] = 1'b1;
                buy_price = price_of(i);
            end
        end
        buy_hit = (buy_oh != '0) && (credit >= buy_price);
    end

    change_select u_change_select (
        .credit   (credit),
        .qempty   (QEmpty),
        .dempty   (DEmpty),
        .nempty   (NEmpty),
        .tmo_mask (mask),
        .coin     (sel_coin),
        .value    (sel_value)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            credit <= '0;
            hval   <= '0;
            item   <= '0;
            vcnt   <= '0;
            tcnt   <= '0;
            mask   <= '0;
            req    <= 1'b0;
            hcoin  <= COIN_NONE;
            reject <= 1'b0;
            error  <= 1'b0;
        end else begin
            credit <= credit_n;
            hval   <= hval_n;
            item   <= item_n;
            vcnt   <= vcnt_n;
            tcnt   <= tcnt_n;
            mask   <= mask_n;
            req    <= req_n;
            hcoin  <= hcoin_n;
            reject <= reject_n;
            error  <= error_n;
        end
    end

    always_comb begin
        state_n  = state;
        credit_n = credit;
        hval_n   = hval;
        item_n   = item;
        vcnt_n   = vcnt;
        tcnt_n   = tcnt;
        mask_n   = mask;
        req_n    = req;
        hcoin_n  = hcoin;
        error_n  = error;
        reject_n = coin_any && !(state == ST_IDLE || state == ST_CREDIT);
        case (state)
            ST_IDLE, ST_CREDIT: begin
                mask_n = '0;
                if (coin_any) begin
                    if (credit_plus > 8'(MAX_CREDIT)) begin
                        reject_n = 1'b1;
                    end else begin
                        credit_n = credit_plus[6:0];
                        error_n  = 1'b0;
                    end
                end
                // Affordability uses pre-coin credit; any accepted coin still lands.
                if (buy_hit) begin
                    credit_n = credit_n - buy_price;
                    item_n   = buy_oh;
                    vcnt_n   = '0;
                    state_n  = ST_VEND;
                end else if (Refund && state == ST_CREDIT) begin
                    state_n = ST_CHG_SEL;
                end else begin
                    state_n = (credit_n == '0) ? ST_IDLE : ST_CREDIT;
                end
            end
            ST_VEND: begin
                if (vcnt == VW'(VEND_CYCLES - 1)) state_n = ST_CHG_SEL;
                else                              vcnt_n  = vcnt + 1'b1;
            end
            ST_CHG_SEL: begin
                if (credit == '0) begin
                    state_n = ST_IDLE;
                end else if (sel_coin != COIN_NONE) begin
                    req_n   = 1'b1;
                    hcoin_n = sel_coin;
                    hval_n  = sel_value;
                    tcnt_n  = '0;
                    state_n = ST_CHG_WAIT;
                end else begin
                    error_n = 1'b1;
                    state_n = ST_CREDIT;
                end
            end
            ST_CHG_WAIT: begin
                if (HopperAck) begin
                    credit_n = credit - hval;
                    req_n    = 1'b0;
                    hcoin_n  = COIN_NONE;
                    state_n  = ST_CHG_GAP;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    mask_n  = mask | coin_mask_bit(hcoin);
                    req_n   = 1'b0;
                    hcoin_n = COIN_NONE;
                    state_n = ST_CHG_GAP;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ST_CHG_GAP: state_n = ST_CHG_SEL;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        Vending = (state == ST_VEND) ? item : 4'b0000;
        Busy    = (state == ST_VEND) || (state == ST_CHG_SEL) ||
                  (state == ST_CHG_WAIT) || (state == ST_CHG_GAP);
    end

    assign Credit     = credit;
    assign HopperReq  = req;
    assign HopperCoin = hcoin;
    assign Reject     = reject;
    assign Error      = error;

endmodule

// File: tb/tb_vend_sequencer.sv
// Randomized bench for vend_sequencer against a transaction-level credit and
// greedy-payout model, with a bench-driven hopper that acks or withholds.
module tb_vend_sequencer;

    logic       Clock = 1'b0;
    logic       Reset, Quarters, Dimes, Nickles, Refund, HopperAck, QEmpty, DEmpty, NEmpty;
    logic [3:0] Buy;
    logic [6:0] Credit;
    logic [3:0] Vending;
    logic       HopperReq, Reject, Busy, Error;
    logic [1:0] HopperCoin;

    int  n_pass = 0;
    int  n_chk  = 0;
    int  m_credit = 0;
    bit  m_error  = 1'b0;
    bit  withhold_q = 1'b0;
    int  prices[4] = '{25, 50, 65, 85};
    int  exp_coins[$];
    int  exp_rem, exp_tmo;
    bit  exp_err;

    vend_sequencer dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Quarters   (Quarters),
        .Dimes      (Dimes),
        .Nickles    (Nickles),
        .Buy        (Buy),
        .Refund     (Refund),
        .HopperAck  (HopperAck),
        .QEmpty     (QEmpty),
        .DEmpty     (DEmpty),
        .NEmpty     (NEmpty),
        .Credit     (Credit),
        .Vending    (Vending),
        .HopperReq  (HopperReq),
        .HopperCoin (HopperCoin),
        .Reject     (Reject),
        .Busy       (Busy),
        .Error      (Error)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int coin_val(input logic [1:0] code);
        case (code)
            2'b01:   return 25;
            2'b10:   return 10;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_credit"},  int'(Credit), 0);
        chk({pfx, "_vending"}, int'(Vending), 0);
        chk({pfx, "_req"},     int'(HopperReq), 0);
        chk({pfx, "_coin"},    int'(HopperCoin), 0);
        chk({pfx, "_reject"},  int'(Reject), 0);
        chk({pfx, "_error"},   int'(Error), 0);
        chk({pfx, "_busy"},    int'(Busy), 0);
    endtask

    // Change owed paid largest-first from stocked tubes; a withheld quarter
    // is given up on once and never offered again in that transaction.
    task automatic payout_model(input int c0);
        int  c, v;
        bit  q_dead;
        c = c0;
        q_dead = 1'b0;
        exp_coins.delete();
        exp_tmo = 0;
        exp_err = 1'b0;
        while (c > 0) begin
            v = 0;
            if (c >= 25 && !QEmpty && !q_dead) v = 25;
            else if (c >= 10 && !DEmpty)       v = 10;
            else if (c >= 5 && !NEmpty)        v = 5;
            if (v == 0) begin
                exp_err = 1'b1;
                break;
            end
            if (v == 25 && withhold_q) begin
                q_dead = 1'b1;
                exp_tmo++;
            end else begin
                exp_coins.push_back(v);
                c -= v;
            end
        end
        exp_rem = c;
    endtask

    task automatic txn(input logic [3:0] buy, input bit rf, input bit q, input bit d, input bit n,
                       input bit abort_d);
        int pre, sum, idx, vend_oh, exp_rej, exp_first;
        int cyc, vend_cnt, vend_bad, first_req, wait_cnt, delay, tmo_seen, glitch;
        bit busy_exp, prev_req, inj, done;
        logic [1:0] last_coin;
        int got[$];
        pre = m_credit;
        sum = (q ? 25 : 0) + (d ? 10 : 0) + (n ? 5 : 0);
        exp_rej = 0;
        if (sum > 0) begin
            if (pre + sum > 95) exp_rej = 1;
            else begin
                m_credit = pre + sum;
                m_error  = 1'b0;
            end
        end
        idx = -1;
        for (int i = 0; i < 4; i++) if (buy[i] && idx < 0) idx = i;
        busy_exp = 1'b0;
        vend_oh  = 0;
        if (idx >= 0 && pre >= prices[idx]) begin
            m_credit -= prices[idx];
            busy_exp = 1'b1;
            vend_oh  = 1 << idx;
        end else if (rf && pre > 0) begin
            busy_exp = 1'b1;
        end

        Quarters = q; Dimes = d; Nickles = n; Buy = buy; Refund = rf;
        tick();
        Quarters = 1'b0; Dimes = 1'b0; Nickles = 1'b0; Buy = 4'b0; Refund = 1'b0;
        chk("reject", int'(Reject), exp_rej);
        if (!busy_exp) begin
            chk("credit", int'(Credit), m_credit);
            chk("vending_idle", int'(Vending), 0);
            chk("busy_idle", int'(Busy), 0);
            chk("error", int'(Error), int'(m_error));
            return;
        end

        payout_model(m_credit);
        exp_first = (exp_coins.size() + exp_tmo > 0) ? ((vend_oh != 0) ? 6 : 2) : 0;
        vend_cnt = 0; vend_bad = 0; first_req = 0; wait_cnt = 0; delay = 1;
        tmo_seen = 0; glitch = 0; prev_req = 1'b0; inj = 1'b0; done = 1'b0;
        last_coin = 2'b00;
        for (cyc = 1; cyc <= 400; cyc++) begin
            if (cyc > 1) begin
                tick();
                HopperAck = 1'b0;
                Dimes = 1'b0;
            end
            if (cyc == 2 && inj) chk("busy_reject", int'(Reject), 1);
            if (vend_oh != 0 && int'(Vending) == vend_oh) vend_cnt++;
            else if (Vending != 4'b0) vend_bad++;
            if (HopperReq) begin
                if (!prev_req) begin
                    if (first_req == 0) first_req = cyc;
                    wait_cnt = 0;
                    delay = $urandom_range(1, 6);
                end else if (HopperCoin != last_coin) begin
                    glitch++;
                end
                wait_cnt++;
                if (abort_d && HopperCoin == 2'b10) begin
                    Reset = 1'b1;
                    tick();
                    Reset = 1'b0;
                    check_all_zero("rst_mid");
                    m_credit = 0;
                    m_error  = 1'b0;
                    return;
                end
                if (!(withhold_q && HopperCoin == 2'b01) && wait_cnt == delay) begin
                    HopperAck = 1'b1;
                    got.push_back(coin_val(HopperCoin));
                end
            end else if (prev_req && withhold_q && last_coin == 2'b01) begin
                tmo_seen++;
                chk("tmo_len", wait_cnt, 15);
            end
            prev_req  = HopperReq;
            last_coin = HopperCoin;
            if (cyc == 1) begin
                inj = ($urandom_range(0, 1) == 1);
                Dimes = inj;
            end
            if (cyc > 1 && !Busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("done", int'(done), 1);
        chk("vend_cycles", vend_cnt, (vend_oh != 0) ? 4 : 0);
        chk("vend_stray", vend_bad, 0);
        chk("first_req", first_req, exp_first);
        chk("tmo_count", tmo_seen, exp_tmo);
        chk("n_coins", got.size(), exp_coins.size());
        for (int i = 0; i < got.size() && i < exp_coins.size(); i++) chk("coin", got[i], exp_coins[i]);
        chk("coin_hold", glitch, 0);
        m_credit = exp_rem;
        if (exp_err) m_error = 1'b1;
        chk("credit_end", int'(Credit), m_credit);
        chk("error_end", int'(Error), int'(m_error));
    endtask

    initial begin
        Reset = 1'b1; Quarters = 1'b0; Dimes = 1'b0; Nickles = 1'b0; Buy = 4'b0; Refund = 1'b0;
        HopperAck = 1'b0; QEmpty = 1'b0; DEmpty = 1'b0; NEmpty = 1'b0;
        repeat (2) tick();
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        // Q,Q,D then buy item 0: 35c change as Q then D
        txn(4'b0000, 0, 1, 0, 0, 0);
        txn(4'b0000, 0, 1, 0, 0, 0);
        txn(4'b0000, 0, 0, 1, 0, 0);
        txn(4'b0001, 0, 0, 0, 0, 0);

        // Summed coins, saturation at 95 and rejected dime
        txn(4'b0000, 0, 1, 1, 1, 0);
        txn(4'b0000, 0, 1, 0, 0, 0);
        txn(4'b0000, 0, 1, 0, 0, 0);
        txn(4'b0000, 0, 0, 0, 1, 0);
        txn(4'b0000, 0, 0, 1, 0, 0);
        txn(4'b0000, 1, 0, 0, 0, 0);

        // Quarter tube empty: 30c returned as three dimes
        txn(4'b0000, 0, 1, 0, 1, 0);
        QEmpty = 1'b1;
        txn(4'b0000, 1, 0, 0, 0, 0);
        QEmpty = 1'b0;

        // Nickel tube empty with 5c owed: Error, then cleared by a coin
        txn(4'b0000, 0, 0, 0, 1, 0);
        NEmpty = 1'b1;
        txn(4'b0000, 1, 0, 0, 0, 0);
        NEmpty = 1'b0;
        txn(4'b0000, 0, 0, 0, 1, 0);
        txn(4'b0000, 1, 0, 0, 0, 0);

        // Multi-bit buy, then an unaffordable buy ignored
        txn(4'b0000, 0, 1, 1, 1, 0);
        txn(4'b0011, 0, 0, 0, 0, 0);
        txn(4'b0000, 0, 0, 1, 0, 0);
        txn(4'b0000, 0, 0, 1, 0, 0);
        txn(4'b0010, 0, 0, 0, 0, 0);
        txn(4'b0010, 1, 0, 0, 0, 0);
        txn(4'b0000, 1, 0, 0, 0, 0);

        // Withheld quarter ack: timeout, then D,D,N; then reset mid dime request
        withhold_q = 1'b1;
        txn(4'b0000, 0, 1, 0, 0, 0);
        txn(4'b0000, 1, 0, 0, 0, 0);
        txn(4'b0000, 0, 1, 0, 0, 0);
        txn(4'b0000, 1, 0, 0, 0, 1);
        withhold_q = 1'b0;

        for (int k = 0; k < 80; k++) begin
            QEmpty = ($urandom_range(0, 6) == 0);
            DEmpty = ($urandom_range(0, 6) == 0);
            NEmpty = ($urandom_range(0, 6) == 0);
            withhold_q = ($urandom_range(0, 4) == 0);
            txn(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000,
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Transaction controller for the vending machine datapath. It owns the credit register and accepts coin pulses. It arbitrates Buy and Refund requests, drives the one-hot Vending strobe, and pays out change one coin at a time through a req/ack handshake to the coin hopper. Greedy payout uses quarter, then dime, then nickel, and respects hopper-empty flags. The block sits between the coin counters/buttons and the display/parser logic, and replaces ad-hoc summing with a single sequenced owner of credit.

Parameters:
MAX_CREDIT, 95, credit saturation limit in cents; must fit in 7 bits.
PRICE0..PRICE3, 25/50/65/85, item prices in cents, multiples of 5.
VEND_CYCLES, 4, cycles the Vending strobe is held.
ACK_TIMEOUT, 15, cycles HopperReq may wait for HopperAck.

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
Quarters  in  1  one-cycle pulse, 25c inserted (pre-synchronised)
Dimes  in  1  one-cycle pulse, 10c
Nickles  in  1  one-cycle pulse, 5c
Buy  in  4  item request, bit i selects PRICEi
Refund  in  1  return all credit
HopperAck  in  1  hopper has ejected the requested coin
QEmpty, DEmpty, NEmpty  in  1 each  hopper tube empty
Credit  out  7  current credit in cents
Vending  out  4  one-hot dispense strobe
HopperReq  out  1  coin ejection request
HopperCoin  out  2  01=quarter, 10=dime, 11=nickel, 00 when idle
Reject  out  1  one-cycle pulse, coins refused
Busy  out  1  high in VEND/CHG_SEL/CHG_WAIT/CHG_GAP
Error  out  1  sticky: change could not be fully paid

Behaviour:
- Clocking and reset: one clock, Clock. Reset is synchronous and active-high. While Reset is high at an edge, every register clears: state=IDLE, Credit=0, Vending=0, HopperReq=0, HopperCoin=00, Reject=0, Error=0, timeout counter=0, per-transaction empty masks=0. Reset mid-operation abandons the transaction; credit is lost and no further ack is awaited.
- States: IDLE (Credit=0), CREDIT, VEND, CHG_SEL, CHG_WAIT, CHG_GAP.
- Coins are accepted only in IDLE/CREDIT.
  - Same-cycle pulses are summed.
  - If Credit+sum > MAX_CREDIT, all of that cycle's coins are refused and Reject pulses for one cycle.
  - Otherwise Credit updates at the next edge and Error clears.
  - Coins in any other state are refused with Reject.
- Buy in IDLE/CREDIT:
  - Multiple bits set: lowest index wins.
  - If Credit >= PRICEi: Credit -= PRICEi at the next edge and the state goes to VEND.
  - Otherwise the request is ignored with no state change.
  - Buy and coin in the same cycle: the coin is evaluated first and the buy is checked against the pre-coin credit.
- Refund in CREDIT goes to CHG_SEL. Buy and Refund in the same cycle: an affordable Buy wins and Refund is dropped (change follows anyway). Refund in IDLE is a no-op.
- VEND:
  - Vending = one-hot of the selected item for exactly VEND_CYCLES cycles, starting the cycle after the Buy edge.
  - Then CHG_SEL.
  - Buy and Refund are ignored while Busy.
- CHG_SEL, one cycle:
  - Credit==0: go to IDLE.
  - Else pick the largest coin with value <= Credit, tube not empty and not timed-out this transaction. Set HopperReq=1 and HopperCoin, and go to CHG_WAIT.
  - No coin eligible: set Error=1 and go to CREDIT with the remaining credit kept.
- CHG_WAIT:
  - HopperReq and HopperCoin are held stable.
  - On HopperAck, Credit -= the coin value, HopperReq drops at the next edge, and the state goes to CHG_GAP.
  - If ACK_TIMEOUT cycles pass without an ack, that coin type is masked for the rest of the transaction, the request drops, and the state goes to CHG_GAP.
- CHG_GAP: HopperReq is low for exactly one cycle, then CHG_SEL. HopperAck outside CHG_WAIT is ignored.
- Arithmetic: 7-bit unsigned throughout; subtraction never underflows by construction.
- Latency: the first HopperReq is asserted 1 cycle after the VEND exit, or 1 cycle after Refund.

Decomposition:
- Shared package vend_pkg holds:
  - state enum;
  - coin code enum (COIN_NONE/Q/D/N);
  - coin value constants 25/10/5;
  - MAX_CREDIT default.
- One natural sub-module, change_select: combinational. Takes Credit, the empty flags and the timeout masks, and returns the coin code and value.

Test Plan:
1. Q,Q,D (60c), Buy=0001 (25c) -> Vending=0001 for 4 cycles, then 35c change paid as Q then D, with HopperReq low 1 cycle between. Credit=0, back to IDLE.
2. Q+D+N in the same cycle from 0 -> Credit=40. At Credit=90, a Nickel gives 95, then a Dime -> Reject pulse and Credit stays 95.
3. Credit=30, Refund with QEmpty=1 -> D, D, D dispensed, Credit=0, Error=0.
4. Credit=5, Refund with NEmpty=1 -> Error=1, state CREDIT, Credit=5. Then a nickel insert -> Error=0 and Credit=10.
5. Credit=40, Buy=0011 -> item 0 vends and 15c is returned. Credit=20, Buy=0010 (50c) -> ignored with no Vending.
6. HopperAck withheld 15 cycles on a quarter request (Credit=25) -> quarter masked, D, D, N paid. Reset asserted in the middle of the D request -> all outputs 0 next cycle.
